// File: rtl/sprite_update_ctrl.sv
// sprite_update_ctrl: arbitrates NREQ requesters onto a shadow copy of the
// sprite register bank and commits dirty entries in one ordered scan per
// vblank rising edge, so the video side only ever sees whole-frame updates.
module sprite_update_ctrl #(
    parameter int NREQ  = 2,
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    input  logic                 vblank,
    output logic                 sprite_we,
    output logic [AW-1:0]        sprite_waddr,
    output logic [DW-1:0]        sprite_wdata,
    output logic                 busy,
    output logic                 commit_done
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   scan_idx_q, scan_idx_d;
    logic [GW-1:0]   last_gnt_q;
    logic            vblank_q;
    logic [DW-1:0]   shadow_q [NREGS];
    logic [NREGS-1:0] dirty_q;

    logic            sprite_we_q;
    logic [AW-1:0]   sprite_waddr_q;
    logic [DW-1:0]   sprite_wdata_q;

    logic            gnt_any;
    logic [GW-1:0]   gnt_idx;
    logic [GW:0]     cand;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            vblank_rise;
    logic            last_slot;

    assign vblank_rise = vblank & ~vblank_q;
    assign last_slot   = (scan_idx_q == AW'(NREGS - 1));

    // Round-robin search starting just after the last winner; only in IDLE.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (state_q == IDLE) begin
            for (int off = 1; off <= NREQ; off++) begin
                cand = {1'b0, last_gnt_q} + (GW+1)'(off);
                if (cand >= (GW+1)'(NREQ)) begin
                    cand = cand - (GW+1)'(NREQ);
                end
                if (!gnt_any && req[cand[GW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[GW-1:0];
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Select the winning requester's address (masked into the bank) and data.
    always_comb begin
        wr_addr = req_addr[int'(gnt_idx)*AW +: AW] & AW'(NREGS - 1);
        wr_data = req_data[int'(gnt_idx)*DW +: DW];
    end

    // Next-state logic: a vblank rise starts a full scan, DONE lasts one cycle.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        unique case (state_q)
            IDLE: begin
                if (vblank_rise) begin
                    state_d    = COMMIT;
                    scan_idx_d = '0;
                end
            end
            COMMIT: begin
                if (last_slot) begin
                    state_d = DONE;
                end else begin
                    scan_idx_d = scan_idx_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, scan pointer, vblank history and arbitration pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            vblank_q   <= 1'b0;
            last_gnt_q <= GW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            vblank_q   <= vblank;
            if (gnt_any) begin
                last_gnt_q <= gnt_idx;
            end
        end
    end

    // Shadow bank: accepted writes set dirty; each commit slot clears its bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                shadow_q[r] <= '0;
            end
            dirty_q <= '0;
        end else begin
            if (gnt_any) begin
                shadow_q[wr_addr] <= wr_data;
                dirty_q[wr_addr]  <= 1'b1;
            end
            if (state_q == COMMIT) begin
                dirty_q[scan_idx_q] <= 1'b0;
            end
        end
    end

    // Bank write port: one slot per COMMIT cycle; address/data hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sprite_we_q    <= 1'b0;
            sprite_waddr_q <= '0;
            sprite_wdata_q <= '0;
        end else if (state_q == COMMIT) begin
            sprite_we_q    <= dirty_q[scan_idx_q];
            sprite_waddr_q <= scan_idx_q;
            sprite_wdata_q <= shadow_q[scan_idx_q];
        end else begin
            sprite_we_q    <= 1'b0;
        end
    end

    assign sprite_we    = sprite_we_q;
    assign sprite_waddr = sprite_waddr_q;
    assign sprite_wdata = sprite_wdata_q;
    assign busy         = (state_q == COMMIT);
    assign commit_done  = (state_q == DONE);

endmodule

// File: tb/tb_sprite_update_ctrl.sv
// Directed bench for sprite_update_ctrl: arbitration order, shadow overwrite,
// commit ordering/timing, stalls during commit, and reset mid-commit.
module tb_sprite_update_ctrl;

    localparam int NREQ  = 2;
    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic                vblank;
    logic                sprite_we;
    logic [AW-1:0]       sprite_waddr;
    logic [DW-1:0]       sprite_wdata;
    logic                busy;
    logic                commit_done;

    int n_checks = 0;
    int n_err    = 0;

    // Bank-write monitor state
    int          cyc    = 0;
    int          bstart = 0;
    logic        busy_prev = 1'b0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          ws_q[$];

    sprite_update_ctrl #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .gnt          (gnt),
        .vblank       (vblank),
        .sprite_we    (sprite_we),
        .sprite_waddr (sprite_waddr),
        .sprite_wdata (sprite_wdata),
        .busy         (busy),
        .commit_done  (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every bank write with its slot number relative to the start of busy
    always @(negedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= busy;
        if (busy && !busy_prev) bstart <= cyc;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (commit_done) done_cnt <= done_cnt + 1;
        if (sprite_we) begin
            wa_q.push_back(32'(sprite_waddr));
            wd_q.push_back(sprite_wdata);
            ws_q.push_back(cyc - bstart - 1);
        end
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        ws_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        vblank = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Single write from requester i; waits a bounded time for the grant.
    task automatic wr(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        int waited;
        set_req(i, a, d);
        #1;
        waited = 0;
        while (!gnt[i] && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("wr_grant", 64'(gnt[i]), 64'd1);
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!commit_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(n < 40), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_commit();
        clear_mon();
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        wait_done();
    endtask

    task automatic check_commit(string tag, int nwr);
        check({tag, "_busy"}, 64'(busy_cnt), 64'(NREGS));
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_nwr"}, 64'(wa_q.size()), 64'(nwr));
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        vblank   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_we", 64'(sprite_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(commit_done), 64'd0);
        check("rst_waddr", 64'(sprite_waddr), 64'd0);
        check("rst_wdata", 64'(sprite_wdata), 64'd0);
        do_reset();

        // 1: single write, committed in slot 3
        wr(0, 4'd3, 32'h0000_00A5);
        run_commit();
        check_commit("t1", 1);
        if (wa_q.size() == 1) begin
            check("t1_addr", 64'(wa_q[0]), 64'd3);
            check("t1_data", 64'(wd_q[0]), 64'hA5);
            check("t1_slot", 64'(ws_q[0]), 64'd3);
        end
        check("t1_idle_we", 64'(sprite_we), 64'd0);

        // 2: both requesters held, grants alternate starting with req[0]
        do_reset();
        set_req(0, 4'd0, 32'h100);
        set_req(1, 4'd1, 32'h101);
        #1;
        for (int k = 0; k < 8; k++) begin
            int r;
            int j;
            r = k % 2;
            check("t2_arb", 64'(gnt), 64'(1 << r));
            @(negedge clk);
            j = k / 2 + 1;
            if (j < 4) set_req(r, 4'(2 * j + r), 32'h100 + 32'(2 * j + r));
            else req[r] = 1'b0;
            #1;
        end
        check("t2_nogrant", 64'(gnt), 64'd0);
        run_commit();
        check_commit("t2", 8);
        if (wa_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t2_addr", 64'(wa_q[i]), 64'(i));
                check("t2_data", 64'(wd_q[i]), 64'(32'h100 + 32'(i)));
                check("t2_slot", 64'(ws_q[i]), 64'(i));
            end
        end

        // 3: rewrite of a dirty entry, last write wins
        wr(1, 4'd5, 32'h11);
        wr(1, 4'd5, 32'h22);
        run_commit();
        check_commit("t3", 1);
        if (wa_q.size() == 1) begin
            check("t3_addr", 64'(wa_q[0]), 64'd5);
            check("t3_data", 64'(wd_q[0]), 64'h22);
        end

        // 4: request held through an empty commit stalls, then lands next frame
        begin
            int n;
            clear_mon();
            vblank = 1'b1;
            @(negedge clk);
            vblank = 1'b0;
            set_req(0, 4'd7, 32'h77);
            #1;
            n = 0;
            while ((busy || commit_done) && n < 40) begin
                check("t4_stall", 64'(gnt), 64'd0);
                @(negedge clk);
                #1;
                n++;
            end
            check("t4_stall_len", 64'(n), 64'(NREGS + 1));
            check("t4_grant", 64'(gnt), 64'd1);
            @(negedge clk);
            req[0] = 1'b0;
            @(negedge clk);
            check_commit("t4a", 0);
        end
        run_commit();
        check_commit("t4b", 1);
        if (wa_q.size() == 1) begin
            check("t4_addr", 64'(wa_q[0]), 64'd7);
            check("t4_data", 64'(wd_q[0]), 64'h77);
        end

        // 5: grant in the same cycle as the vblank rise is included in slot 0
        clear_mon();
        set_req(0, 4'd0, 32'hDEAD_BEEF);
        vblank = 1'b1;
        #1;
        check("t5_grant", 64'(gnt), 64'd1);
        @(negedge clk);
        req[0] = 1'b0;
        vblank = 1'b0;
        wait_done();
        check_commit("t5", 1);
        if (wa_q.size() == 1) begin
            check("t5_addr", 64'(wa_q[0]), 64'd0);
            check("t5_data", 64'(wd_q[0]), 64'hDEAD_BEEF);
            check("t5_slot", 64'(ws_q[0]), 64'd0);
        end

        // 6: reset at slot 6 aborts; entry 9 never reaches the bank
        wr(0, 4'd2, 32'h2222_2222);
        wr(1, 4'd9, 32'h9999_9999);
        clear_mon();
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_we", 64'(sprite_we), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t6_addr", 64'(wa_q[0]), 64'd2);
            check("t6_data", 64'(wd_q[0]), 64'h2222_2222);
        end
        run_commit();
        check_commit("t6b", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
